clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//  Parametrised N-channel fabric clock divider/enable generator behind the PLL output clock (clkout).
//  Each channel has a runtime-programmable divisor and phase offset, with glitch-free divisor changes.
//  All channels can be resynchronised to a common phase.
//  Feeds the phase-detector reference/feedback paths; generalises the fixed-ratio PLL CLKOUTD tap.
// PARAMETERS
//  NUM_CH   2   number of divider channels (1..8)
//  DIV_W    8   width of divisor/phase fields
//  DEF_DIV  5   divisor loaded into every channel at reset (clamped like cfg_div)
// PORTS
//  clkin       in   1                  sole clock (PLL output clock domain)
//  rst_n       in   1                  asynchronous active-low reset
//  en          in   NUM_CH             per-channel run enable
//  sync        in   1                  one-cycle pulse: realign all running channels to their phase
//  cfg_valid   in   1                  config write request
//  cfg_ready   out  1                  config write accepted when cfg_valid&&cfg_ready
//  cfg_ch      in   $clog2(NUM_CH)     target channel (max(1,...) bits)
//  cfg_div     in   DIV_W              new divisor
//  cfg_phase   in   DIV_W              new phase offset (counter start value)
//  div_out     out  NUM_CH             divided square wave per channel
//  clk_en_out  out  NUM_CH             one-cycle enable pulse per period
//  pending     out  NUM_CH             channel holds an unapplied config
// BEHAVIOUR
//  Reset: cnt=0, div=clamp(DEF_DIV), phase=0, pending=0, state=OFF; div_out=0, clk_en_out=0, cfg_ready=1.
//  Clamp: divisor 0 or 1 is stored as 2. Phase >= div is stored as 0.
//  Per-channel FSM:
//    OFF: cnt held 0.
//    OFF->RUN when en[i]=1; cnt starts at phase.
//    RUN: cnt counts 0..div-1 and wraps. Wrap = cnt==div-1.
//    RUN->PEND on an accepted write to channel i.
//    PEND: keeps counting on the old div. At wrap it loads new div/phase, cnt<=0, pending clears, ->RUN.
//    Any state->OFF when en[i]=0, next cycle. A pending config is applied at once on entering OFF.
//  Outputs (registered, lag cnt by 1 cycle):
//    div_out[i]=1 iff cnt<floor(div/2); odd div gives low-biased duty.
//    clk_en_out[i]=1 iff cnt==0.
//    Both are 0 in OFF.
//  cfg_ready = !pending[cfg_ch] (combinational).
//  A write accepted while the channel is OFF applies immediately; pending never sets.
//  A write with cfg_ch>=NUM_CH is accepted and discarded.
//  sync: next cycle every RUN/PEND channel sets cnt<=phase. A PEND channel applies its new div/phase first.
//    sync and wrap in the same cycle: sync wins.
//    sync and cfg accept to the same channel in the same cycle: config applied, then realigned.
//  rst_n asserted mid-operation: everything returns to reset values asynchronously, pending writes dropped.
// CONFIGURATION
//  CLK_DIV_PULSE_EN defined: clk_en_out generated as above.
//  CLK_DIV_PULSE_EN undefined: clk_en_out tied 0 and its flops/decode absent; all else unchanged.
// STRUCTURE
//  Package clk_div_pkg:
//    ch_state_t enum {OFF, RUN, PEND}
//    function clamp_div(div)
//    function clamp_phase(phase, div)
//  Sub-module clk_div_ch: one channel (FSM, counter, output flops), generated NUM_CH times.
//  The top holds cfg decode, cfg_ready mux and sync fan-out.
// TESTING
//  1. Reset release, en=2'b01, DEF_DIV=5 -> ch0 div_out 1,1,0,0,0 repeating, clk_en_out every 5th cycle; ch1 stays 0.
//  2. ch0 running div=5; write div=8 on cycle cnt=2 -> pending=1, cfg_ready=0 for ch0; old period completes; then period 8 (4 hi/4 lo), no runt pulse.
//  3. ch0 div=4 phase=0, ch1 div=4 phase=2, pulse sync -> ch1 clk_en_out exactly 2 cycles before ch0's, repeating.
//  4. Write div=0, phase=7 -> stored div=2, phase=0; div_out toggles every cycle.
//  5. sync coincident with wrap and with a pending write -> new div in effect from the realigned start; pending=0.
//  6. rst_n low mid-PEND -> outputs 0 immediately, pending=0, div=DEF_DIV after release; build with CLK_DIV_PULSE_EN off -> clk_en_out constant 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and clamp helpers for the multi-channel clock divider.
// Helpers take 32-bit operands, so DIV_W must not exceed 32.
package clk_div_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } ch_state_t;

  // Divisors below 2 cannot produce a square wave, so they are raised to 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

  function automatic logic [31:0] clamp_phase(input logic [31:0] phase, input logic [31:0] div);
    return (phase >= div) ? 32'd0 : phase;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: OFF/RUN/PEND FSM, period counter and registered outputs.
// Optional feature macro: CLK_DIV_PULSE_EN (per-period enable pulse on clk_en_out).
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  output logic             div_out,
  output logic             clk_en_out,
  output logic             pending,
  output ch_state_t        state_dbg
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_div(32'(DEF_DIV)));

  ch_state_t        state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx;
  logic [DIV_W-1:0] div, div_nx;
  logic [DIV_W-1:0] phase, phase_nx;
  logic [DIV_W-1:0] new_div, new_div_nx;
  logic [DIV_W-1:0] new_phase, new_phase_nx;
  logic [DIV_W-1:0] w_div, w_phase;
  logic [DIV_W-1:0] cnt_inc;
  logic             wrap;

  // The phase is clamped against the divisor it will be used with.
  assign w_div   = DIV_W'(clamp_div(32'(wr_div)));
  assign w_phase = DIV_W'(clamp_phase(32'(wr_phase), 32'(w_div)));
  assign wrap    = (cnt == div - DIV_W'(1));
  assign cnt_inc = wrap ? '0 : cnt + DIV_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OFF;
      cnt       <= '0;
      div       <= RST_DIV;
      phase     <= '0;
      new_div   <= RST_DIV;
      new_phase <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      div       <= div_nx;
      phase     <= phase_nx;
      new_div   <= new_div_nx;
      new_phase <= new_phase_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    div_nx       = div;
    phase_nx     = phase;
    new_div_nx   = new_div;
    new_phase_nx = new_phase;
    case (state)
      OFF: begin
        cnt_nx = '0;
        if (wr) begin
          div_nx   = w_div;
          phase_nx = w_phase;
        end
        if (en) begin
          state_nx = RUN;
          cnt_nx   = wr ? w_phase : phase;
        end
      end
      RUN: begin
        if (!en) begin
          state_nx = OFF;
          cnt_nx   = '0;
          if (wr) begin
            div_nx   = w_div;
            phase_nx = w_phase;
          end
        end else if (sync) begin
          // A write landing with sync is applied first, then realigned.
          cnt_nx = phase;
          if (wr) begin
            div_nx   = w_div;
            phase_nx = w_phase;
            cnt_nx   = w_phase;
          end
        end else begin
          cnt_nx = cnt_inc;
          if (wr) begin
            new_div_nx   = w_div;
            new_phase_nx = w_phase;
            state_nx     = PEND;
          end
        end
      end
      PEND: begin
        if (!en || sync || wrap) begin
          div_nx   = new_div;
          phase_nx = new_phase;
          state_nx = en ? RUN : OFF;
          cnt_nx   = (en && sync) ? new_phase : '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: begin
        state_nx = OFF;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_out <= 1'b0;
    end else begin
      div_out <= (state != OFF) && (cnt < (div >> 1));
    end
  end

`ifdef CLK_DIV_PULSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_en_out <= 1'b0;
    end else begin
      clk_en_out <= (state != OFF) && (cnt == '0);
    end
  end
`else
  assign clk_en_out = 1'b0;
`endif

  assign pending   = (state == PEND);
  assign state_dbg = state;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel clock divider / enable generator: config decode, cfg_ready mux, sync fan-out.
// Optional feature macro: CLK_DIV_PULSE_EN (enables clk_en_out pulses in every channel).
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 5
) (
  input  logic                                          clkin,
  input  logic                                          rst_n,
  input  logic [NUM_CH-1:0]                             en,
  input  logic                                          sync,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [$clog2((NUM_CH > 1) ? NUM_CH : 2)-1:0]  cfg_ch,
  input  logic [DIV_W-1:0]                              cfg_div,
  input  logic [DIV_W-1:0]                              cfg_phase,
  output logic [NUM_CH-1:0]                             div_out,
  output logic [NUM_CH-1:0]                             clk_en_out,
  output logic [NUM_CH-1:0]                             pending,
  output logic [2*NUM_CH-1:0]                           dbg_state
);

  localparam int CH_W = $clog2((NUM_CH > 1) ? NUM_CH : 2);

  logic accept;

  // Handshake: a write transfers on a clkin edge where cfg_valid && cfg_ready;
  // cfg_ready is combinational from cfg_ch, and out-of-range channels always accept.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
    end
  end

  assign accept = cfg_valid && cfg_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_t st;

    clk_div_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk        (clkin),
      .rst_n      (rst_n),
      .en         (en[g]),
      .sync       (sync),
      .wr         (accept && (cfg_ch == CH_W'(g))),
      .wr_div     (cfg_div),
      .wr_phase   (cfg_phase),
      .div_out    (div_out[g]),
      .clk_en_out (clk_en_out[g]),
      .pending    (pending[g]),
      .state_dbg  (st)
    );

    assign dbg_state[2*g +: 2] = st;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (NUM_CH=2, DIV_W=8, DEF_DIV=5).
module tb_clk_div_multi;

  logic       clkin = 1'b0;
  logic       rst_n;
  logic [1:0] en;
  logic       sync;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_phase;
  logic [1:0] div_out;
  logic [1:0] clk_en_out;
  logic [1:0] pending;
  logic [3:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  clk_div_multi #(.NUM_CH(2), .DIV_W(8), .DEF_DIV(5)) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .en         (en),
    .sync       (sync),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_phase  (cfg_phase),
    .div_out    (div_out),
    .clk_en_out (clk_en_out),
    .pending    (pending),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clkin = ~clkin;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_ce(input logic b);
`ifdef CLK_DIV_PULSE_EN
    return b;
`else
    return 1'b0;
`endif
  endfunction

  // advance one edge, return at the following negedge for sampling/driving
  task automatic tick();
    @(posedge clkin);
    @(negedge clkin);
  endtask

  task automatic cfg_set(input logic ch, input logic [7:0] d, input logic [7:0] p);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = d;
    cfg_phase = p;
  endtask

  initial begin
    rst_n = 1'b0; en = 2'b01; sync = 1'b0;
    cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = '0; cfg_phase = '0;
    repeat (2) @(negedge clkin);

    // reset state
    check("rst_div_out", div_out, 2'b00);
    check("rst_clk_en", clk_en_out, 2'b00);
    check("rst_pending", pending, 2'b00);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_state", dbg_state, 4'h0);

    // 1: default divisor 5 on ch0, ch1 disabled
    rst_n = 1'b1;
    tick();
    check("t1_first_edge", div_out, 2'b00);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("t1_div0", div_out[0], (k % 5) < 2);
      check("t1_ce0", clk_en_out[0], exp_ce((k % 5) == 0));
      check("t1_ch1_off", {clk_en_out[1], div_out[1]}, 2'b00);
    end

    // 2: write div=8 while cnt=2; old period completes first
    cfg_set(1'b0, 8'd8, 8'd0);
    check("t2_ready_before", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
    check("t2_out_cnt2", div_out[0], 1'b0);
    check("t2_pending_set", pending, 2'b01);
    check("t2_ready_busy", cfg_ready, 1'b0);
    tick();
    check("t2_out_cnt3", div_out[0], 1'b0);
    check("t2_pending_hold", pending[0], 1'b1);
    tick();
    check("t2_out_cnt4", div_out[0], 1'b0);
    check("t2_pending_clr", pending[0], 1'b0);
    for (int m = 0; m < 16; m++) begin
      tick();
      check("t2_div8", div_out[0], (m % 8) < 4);
      check("t2_ce8", clk_en_out[0], exp_ce((m % 8) == 0));
    end

    // 3: ch0 div4/ph0, ch1 div4/ph2, started out of step, then sync
    en = 2'b00;
    tick();
    tick();
    check("t3_off_out", div_out, 2'b00);
    cfg_set(1'b0, 8'd4, 8'd0);
    tick();
    cfg_set(1'b1, 8'd4, 8'd2);
    tick();
    cfg_valid = 1'b0;
    check("t3_off_no_pend", pending, 2'b00);
    en = 2'b10;
    tick();
    en = 2'b11;
    tick();
    tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int s = 0; s < 8; s++) begin
      tick();
      check("t3_div0", div_out[0], (s % 4) < 2);
      check("t3_div1", div_out[1], ((s + 2) % 4) < 2);
      check("t3_ce0", clk_en_out[0], exp_ce((s % 4) == 0));
      check("t3_ce1", clk_en_out[1], exp_ce(((s + 2) % 4) == 0));
    end

    // 4: div=0, phase=7 clamps to div=2, phase=0
    cfg_set(1'b0, 8'd0, 8'd7);
    check("t4_ready", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
    check("t4_pending_set", pending[0], 1'b1);
    for (int w = 0; w < 8 && pending[0]; w++) tick();
    check("t4_pending_clr", pending[0], 1'b0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      check("t4_toggle", div_out[0], (s % 2) == 0);
      check("t4_ce", clk_en_out[0], exp_ce((s % 2) == 0));
    end

    // 5: sync coincident with wrap while a write is pending
    cfg_set(1'b0, 8'd6, 8'd1);
    tick();
    cfg_valid = 1'b0;
    check("t5_pending_set", pending[0], 1'b1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("t5_pending_clr", pending[0], 1'b0);
    check("t5_ready", cfg_ready, 1'b1);
    for (int s = 0; s < 12; s++) begin
      tick();
      check("t5_div6", div_out[0], ((1 + s) % 6) < 3);
      check("t5_ce6", clk_en_out[0], exp_ce(((1 + s) % 6) == 0));
    end

    // 5b: sync and config accept to the same channel in one cycle
    cfg_set(1'b1, 8'd3, 8'd1);
    sync = 1'b1;
    check("t5b_ready", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
    sync = 1'b0;
    check("t5b_no_pend", pending[1], 1'b0);
    for (int s = 0; s < 6; s++) begin
      tick();
      check("t5b_div3", div_out[1], ((1 + s) % 3) < 1);
      check("t5b_ce3", clk_en_out[1], exp_ce(((1 + s) % 3) == 0));
    end

    // 6: asynchronous reset in PEND drops the write and restores DEF_DIV
    cfg_set(1'b0, 8'd8, 8'd0);
    tick();
    cfg_valid = 1'b0;
    check("t6_pending_set", pending[0], 1'b1);
    rst_n = 1'b0;
    en = 2'b01;
    #1;
    check("t6_rst_div_out", div_out, 2'b00);
    check("t6_rst_clk_en", clk_en_out, 2'b00);
    check("t6_rst_pending", pending, 2'b00);
    check("t6_rst_ready", cfg_ready, 1'b1);
    @(negedge clkin);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t6_div5", div_out[0], (k % 5) < 2);
      check("t6_ce5", clk_en_out[0], exp_ce((k % 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
